line_bus_adapter: RTL and testbench

Serialises whole-line cache commands onto a beat-wide memory bus and reassembles read beats into a full line. It sits directly downstream of the direct-mapped cache: it consumes that cache's `command_*` / `data_to_bus` outputs and drives its `data_from_bus` / `bus_valid` / `bus_ready` inputs. Its other side is a request/beat memory port. One line transfer is in flight at a time.

---
 rtl/line_bus_adapter.sv | 152 +++++++++++++++
 tb/tb_line_bus_adapter.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_bus_adapter.sv
// line_bus_adapter: serialises whole-line cache commands into beats on a
// request/beat memory port and reassembles read beats into a full line.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   command_valid/store   cache line-transfer request and direction
//   command_rready        cache read-ready (unused here)
//   command_addr          line address (offset bits dropped)
//   data_to_bus           line to write, word 0 in the low bits
//   data_from_bus         assembled read line, held until the next read
//   bus_valid / bus_ready one-cycle read-done / write-done pulses
//   mem_req_*             request handshake, line-aligned address, direction
//   mem_w*                write-beat handshake and data
//   mem_rvalid/rdata      read beats, no backpressure

module line_bus_adapter #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    command_valid,
    input  logic                                    command_store,
    input  logic                                    command_rready,
    input  logic [ADDR_WIDTH-1:0]                   command_addr,
    input  logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0] data_to_bus,
    output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0] data_from_bus,
    output logic                                    bus_valid,
    output logic                                    bus_ready,
    output logic                                    mem_req_valid,
    input  logic                                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
    output logic                                    mem_req_store,
    output logic                                    mem_wvalid,
    input  logic                                    mem_wready,
    output logic [DATA_WIDTH-1:0]                   mem_wdata,
    input  logic                                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                   mem_rdata
);

    localparam int N = 2**OFFSET_LENGTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t                   r_state;
    logic [OFFSET_LENGTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_store;
    logic [DATA_WIDTH-1:0]    r_line [N];
    logic [DATA_WIDTH-1:0]    r_buf  [N];
    logic                     r_req_valid;
    logic                     r_wvalid;
    logic                     r_bus_valid;
    logic                     r_bus_ready;

    logic w_last;
    logic w_unused;

    // the beat counter is all ones exactly on the final beat of a line
    assign w_last   = &r_cnt;
    assign w_unused = ^{command_rready, command_addr[OFFSET_LENGTH-1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_store     <= 1'b0;
            r_req_valid <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_ready <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_line[i] <= '0;
                r_buf[i]  <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (command_valid) begin
                        r_addr      <= {command_addr[ADDR_WIDTH-1:OFFSET_LENGTH],
                                        {OFFSET_LENGTH{1'b0}}};
                        r_store     <= command_store;
                        r_req_valid <= 1'b1;
                        r_state     <= S_REQ;
                        if (command_store) begin
                            for (int i = 0; i < N; i++) begin
                                r_line[i] <= data_to_bus[i*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_cnt       <= '0;
                        r_req_valid <= 1'b0;
                        r_wvalid    <= r_store;
                        r_state     <= r_store ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (mem_wready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_wvalid    <= 1'b0;
                            r_bus_ready <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_READ: begin
                    if (mem_rvalid) begin
                        r_buf[r_cnt] <= mem_rdata;
                        r_cnt        <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_bus_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_bus_valid <= 1'b0;
                    r_bus_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_addr;
    assign mem_req_store = r_store;
    assign mem_wvalid    = r_wvalid;
    assign mem_wdata     = r_line[r_cnt];
    assign bus_valid     = r_bus_valid;
    assign bus_ready     = r_bus_ready;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign data_from_bus[g*DATA_WIDTH +: DATA_WIDTH] = r_buf[g];
    end

endmodule

// File: tb/tb_line_bus_adapter.sv
// tb_line_bus_adapter: randomized self-checking bench for line_bus_adapter
// against a transaction-level memory and line-buffer model.

module tb_line_bus_adapter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int OL = 4;
    localparam int N  = 16;
    localparam int L  = DW * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          command_valid;
    logic          command_store;
    logic          command_rready;
    logic [AW-1:0] command_addr;
    logic [L-1:0]  data_to_bus;
    logic [L-1:0]  data_from_bus;
    logic          bus_valid;
    logic          bus_ready;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_store;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    line_bus_adapter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .OFFSET_LENGTH(OL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .command_valid(command_valid),
        .command_store(command_store),
        .command_rready(command_rready),
        .command_addr(command_addr),
        .data_to_bus(data_to_bus),
        .data_from_bus(data_from_bus),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_req_store(mem_req_store),
        .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready),
        .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: memory beats for the next read, expected line buffer
    logic [DW-1:0] rd_words [N];
    logic [L-1:0]  exp_buf;
    logic [DW-1:0] obs_w [$];

    // observations from the last transfer
    int            x_lat;
    int            x_stalls;
    int            x_nbv;
    int            x_nbr;
    int            x_nreq;
    int            x_req_first;
    bit            x_req_stable;
    logic [AW-1:0] x_req_addr;
    logic          x_req_store;

    function automatic logic [L-1:0] words_to_line();
        logic [L-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = rd_words[i];
        return v;
    endfunction

    function automatic int first_diff(input logic [L-1:0] a, input logic [L-1:0] b);
        for (int i = 0; i < N; i++)
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return 0;
    endfunction

    function automatic logic [L-1:0] rand_line();
        logic [L-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = {$urandom, $urandom};
        return v;
    endfunction

    task automatic idle_inputs();
        command_valid  = 1'b0;
        command_store  = 1'b0;
        command_rready = 1'b1;
        command_addr   = '0;
        data_to_bus    = '0;
        mem_req_ready  = 1'b0;
        mem_wready     = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;
    endtask

    // Drives one line transfer from the IDLE cycle it is called in until the
    // response pulse; returns at that pulse cycle. Modes: 0 no stall,
    // 1 low every other cycle, 2 random.
    task automatic run_xfer(input bit st, input logic [AW-1:0] a,
                            input logic [L-1:0] line, input int req_stall,
                            input int wmode, input int rmode, input bit spur);
        int cyc = 0;
        int rw = 0;
        int beats = 0;
        bit hs_pend = 0;
        bit rd = 0;
        bit done = 0;
        bit wtog = 0;
        bit rtog = 0;
        bit v;
        x_lat = -1; x_stalls = 0; x_nbv = 0; x_nbr = 0; x_nreq = 0;
        x_req_first = -1; x_req_stable = 1; x_req_addr = '0; x_req_store = 0;
        obs_w.delete();
        command_valid = 1'b1;
        command_store = st;
        command_addr  = a;
        data_to_bus   = line;
        mem_req_ready = 1'b0;
        mem_wready    = 1'b0;
        mem_rvalid    = spur;
        mem_rdata     = spur ? 64'hFF : '0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            command_valid = 1'($urandom_range(0, 1));
            command_store = 1'($urandom_range(0, 1));
            command_addr  = {$urandom, $urandom};
            data_to_bus   = ~line;
            command_rready = 1'($urandom_range(0, 1));
            if (hs_pend) begin
                rd = !st;
                hs_pend = 0;
            end
            if (bus_valid) x_nbv++;
            if (bus_ready) x_nbr++;
            if (bus_valid || bus_ready) begin
                x_lat = cyc;
                done = 1;
                command_valid = 1'b0;
                mem_req_ready = 1'b0;
                mem_wready    = 1'b0;
                mem_rvalid    = spur;
                mem_rdata     = spur ? 64'hFF : '0;
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
                if (mem_req_valid) begin
                    x_nreq++;
                    if (x_req_first < 0) begin
                        x_req_first = cyc;
                        x_req_addr  = mem_req_addr;
                        x_req_store = mem_req_store;
                    end else if (mem_req_addr !== x_req_addr ||
                                 mem_req_store !== x_req_store) begin
                        x_req_stable = 0;
                    end
                    if (rw < req_stall) begin
                        mem_req_ready = 1'b0;
                        rw++;
                        x_stalls++;
                    end else begin
                        mem_req_ready = 1'b1;
                        hs_pend = 1;
                    end
                end
                if (mem_wvalid) begin
                    v = (wmode == 0) ? 1'b1 :
                        (wmode == 1) ? wtog : 1'($urandom_range(0, 1));
                    wtog = !wtog;
                    mem_wready = v;
                    if (v) obs_w.push_back(mem_wdata);
                    else x_stalls++;
                end else begin
                    mem_wready = 1'($urandom_range(0, 1));
                end
                if (rd && beats < N) begin
                    v = (rmode == 0) ? 1'b1 :
                        (rmode == 1) ? rtog : 1'($urandom_range(0, 1));
                    rtog = !rtog;
                    mem_rvalid = v;
                    if (v) begin
                        mem_rdata = rd_words[beats];
                        beats++;
                    end else begin
                        mem_rdata = {$urandom, $urandom};
                        x_stalls++;
                    end
                end else begin
                    mem_rvalid = spur;
                    mem_rdata  = spur ? 64'hFF : {$urandom, $urandom};
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: no response pulse after %0d cycles, required one", cyc);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        command_valid = 1'b1;
        command_store = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 64'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_from_bus !== '0) begin errors++;
            $display("FAIL reset_dfb: got word0 %h, required 0", data_from_bus[DW-1:0]); end
        checks++;
        if (bus_valid !== 1'b0 || bus_ready !== 1'b0) begin errors++;
            $display("FAIL reset_bus: got %b%b, required 00", bus_valid, bus_ready); end
        checks++;
        if (mem_req_valid !== 1'b0 || mem_req_store !== 1'b0) begin errors++;
            $display("FAIL reset_req: got %b%b, required 00", mem_req_valid, mem_req_store); end
        checks++;
        if (mem_req_addr !== '0) begin errors++;
            $display("FAIL reset_addr: got %h, required 0", mem_req_addr); end
        checks++;
        if (mem_wvalid !== 1'b0 || mem_wdata !== '0) begin errors++;
            $display("FAIL reset_w: got %b %h, required 0 0", mem_wvalid, mem_wdata); end
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++;
            $display("FAIL reset_release: mem_req_valid got %b, required 0", mem_req_valid); end
        exp_buf = '0;
    endtask

    task automatic test_read_zero_wait();
        for (int i = 0; i < N; i++) rd_words[i] = 64'(32'hA0 + i);
        run_xfer(0, 64'h1234, '0, 0, 0, 0, 0);
        exp_buf = words_to_line();
        checks++;
        if (x_req_addr !== 64'h1230) begin errors++;
            $display("FAIL rd_req_addr: got %h, required 1230", x_req_addr); end
        checks++;
        if (x_lat !== 18 || x_nbv !== 1 || x_nbr !== 0) begin errors++;
            $display("FAIL rd_latency: got lat %0d bv %0d br %0d, required 18 1 0",
                     x_lat, x_nbv, x_nbr); end
        checks++;
        if (data_from_bus !== exp_buf) begin errors++;
            $display("FAIL rd_data: word %0d got %h, required %h",
                     first_diff(data_from_bus, exp_buf),
                     data_from_bus[first_diff(data_from_bus, exp_buf)*DW +: DW],
                     exp_buf[first_diff(data_from_bus, exp_buf)*DW +: DW]); end
        @(posedge clk); #1;
        checks++;
        if (bus_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++;
            $display("FAIL rd_single_pulse: bus_valid %b req %b, required 0 0",
                     bus_valid, mem_req_valid); end
    endtask

    task automatic test_store_stalls();
        logic [L-1:0] line;
        int bad;
        for (int i = 0; i < N; i++) line[i*DW +: DW] = 64'(i);
        run_xfer(1, 64'h5678, line, 0, 1, 0, 0);
        bad = (obs_w.size() != N) ? -2 : -1;
        if (bad == -1)
            for (int i = N - 1; i >= 0; i--)
                if (obs_w[i] !== 64'(i)) bad = i;
        checks++;
        if (bad != -1) begin errors++;
            $display("FAIL st_wdata_seq: %0d beats, first bad index %0d, required 16 beats 0..15",
                     obs_w.size(), bad); end
        checks++;
        if (x_nbr !== 1 || x_nbv !== 0) begin errors++;
            $display("FAIL st_pulses: got br %0d bv %0d, required 1 0", x_nbr, x_nbv); end
        checks++;
        if (x_lat !== N + 2 + x_stalls || x_stalls !== N) begin errors++;
            $display("FAIL st_latency: got %0d stalls %0d, required %0d stalls 16",
                     x_lat, x_stalls, N + 2 + N); end
        checks++;
        if (x_req_store !== 1'b1 || x_req_addr !== 64'h5670) begin errors++;
            $display("FAIL st_req: got %b %h, required 1 5670", x_req_store, x_req_addr); end
        checks++;
        if (data_from_bus !== exp_buf) begin errors++;
            $display("FAIL st_buf_kept: word %0d changed", first_diff(data_from_bus, exp_buf)); end
        @(posedge clk); #1;
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < N; i++) rd_words[i] = {$urandom, $urandom};
        run_xfer(0, 64'hDEAD_BEEF_0000_004F, '0, 3, 0, 0, 0);
        exp_buf = words_to_line();
        checks++;
        if (x_req_stable !== 1'b1 || x_nreq !== 4) begin errors++;
            $display("FAIL rq_stable: stable %0d cycles %0d, required 1 4", x_req_stable, x_nreq); end
        checks++;
        if (x_req_addr !== 64'hDEAD_BEEF_0000_0040 || x_req_store !== 1'b0) begin errors++;
            $display("FAIL rq_addr: got %h %b, required deadbeef00000040 0",
                     x_req_addr, x_req_store); end
        checks++;
        if (x_lat !== 21) begin errors++;
            $display("FAIL rq_latency: got %0d, required 21", x_lat); end
        checks++;
        if (data_from_bus !== exp_buf) begin errors++;
            $display("FAIL rq_data: word %0d wrong", first_diff(data_from_bus, exp_buf)); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_then_writeback();
        logic [L-1:0] line;
        for (int i = 0; i < N; i++) rd_words[i] = {$urandom, $urandom};
        run_xfer(0, 64'h0000_0000_0001_0000, '0, 0, 0, 0, 0);
        exp_buf = words_to_line();
        checks++;
        if (x_nbv !== 1) begin errors++;
            $display("FAIL wb_read_pulse: got %0d, required 1", x_nbv); end
        @(posedge clk); #1;
        line = rand_line();
        run_xfer(1, 64'h0000_0000_0002_0008, line, 0, 0, 0, 0);
        checks++;
        if (x_req_first !== 1) begin errors++;
            $display("FAIL wb_req_gap: request %0d cycles after bus_valid, required 2",
                     x_req_first + 1); end
        checks++;
        if (x_req_addr !== 64'h0000_0000_0002_0000 || x_nbr !== 1) begin errors++;
            $display("FAIL wb_store: addr %h br %0d, required 20000 1", x_req_addr, x_nbr); end
        checks++;
        if (obs_w.size() != N || obs_w[N-1] !== line[(N-1)*DW +: DW] ||
            obs_w[0] !== line[DW-1:0]) begin errors++;
            $display("FAIL wb_wdata: %0d beats, required 16 matching the line", obs_w.size()); end
        checks++;
        if (data_from_bus !== exp_buf) begin errors++;
            $display("FAIL wb_buf_kept: word %0d changed", first_diff(data_from_bus, exp_buf)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        command_valid = 1'b1;
        command_store = 1'b0;
        command_addr  = 64'h7700;
        for (int i = 0; i < N; i++) rd_words[i] = {$urandom, $urandom};
        @(posedge clk); #1;
        command_valid = 1'b0;
        mem_req_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rd_words[b];
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_rdata = rd_words[5];
        @(posedge clk); #1;
        exp_buf = '0;
        checks++;
        if ({bus_valid, bus_ready, mem_req_valid, mem_req_store, mem_wvalid} !== 5'b0 ||
            mem_req_addr !== '0 || mem_wdata !== '0) begin errors++;
            $display("FAIL mr_outputs: flags %b addr %h, required all 0",
                     {bus_valid, bus_ready, mem_req_valid, mem_req_store, mem_wvalid},
                     mem_req_addr); end
        checks++;
        if (data_from_bus !== '0) begin errors++;
            $display("FAIL mr_buf: word %0d nonzero", first_diff(data_from_bus, '0)); end
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < N; i++) rd_words[i] = {$urandom, $urandom};
        run_xfer(0, 64'h8800, '0, 0, 0, 0, 0);
        exp_buf = words_to_line();
        checks++;
        if (x_req_first !== 1 || x_lat !== 18) begin errors++;
            $display("FAIL mr_fresh_timing: req %0d lat %0d, required 1 18", x_req_first, x_lat); end
        checks++;
        if (data_from_bus !== exp_buf) begin errors++;
            $display("FAIL mr_fresh_data: word %0d wrong", first_diff(data_from_bus, exp_buf)); end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious();
        int nbv = 0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFF;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus_valid) nbv++;
        end
        checks++;
        if (nbv != 0 || data_from_bus !== exp_buf) begin errors++;
            $display("FAIL sp_idle: bus_valid %0d, buffer word %0d differs, required 0 unchanged",
                     nbv, first_diff(data_from_bus, exp_buf)); end
        run_xfer(1, 64'h9900, rand_line(), 0, 2, 0, 1);
        checks++;
        if (x_nbv !== 0 || x_nbr !== 1) begin errors++;
            $display("FAIL sp_write_pulses: bv %0d br %0d, required 0 1", x_nbv, x_nbr); end
        checks++;
        if (data_from_bus !== exp_buf) begin errors++;
            $display("FAIL sp_buf: word %0d got %h, required unchanged",
                     first_diff(data_from_bus, exp_buf),
                     data_from_bus[first_diff(data_from_bus, exp_buf)*DW +: DW]); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_random();
        bit            st;
        logic [AW-1:0] a;
        logic [L-1:0]  line;
        int            bad;
        for (int k = 0; k < 10; k++) begin
            st = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            line = rand_line();
            for (int i = 0; i < N; i++) rd_words[i] = {$urandom, $urandom};
            run_xfer(st, a, line, $urandom_range(0, 3), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if (!st) exp_buf = words_to_line();
            checks++;
            if (x_lat !== N + 2 + x_stalls) begin errors++;
                $display("FAIL rnd%0d_latency: got %0d, required %0d", k, x_lat, N + 2 + x_stalls); end
            checks++;
            if (x_req_addr !== {a[AW-1:OL], 4'h0} || x_req_store !== st || !x_req_stable) begin
                errors++;
                $display("FAIL rnd%0d_req: got %h %b stable %0d, required %h %b 1",
                         k, x_req_addr, x_req_store, x_req_stable, {a[AW-1:OL], 4'h0}, st); end
            checks++;
            if (x_nbv !== (st ? 0 : 1) || x_nbr !== (st ? 1 : 0)) begin errors++;
                $display("FAIL rnd%0d_pulses: bv %0d br %0d, store %b", k, x_nbv, x_nbr, st); end
            if (st) begin
                bad = (obs_w.size() != N) ? -2 : -1;
                if (bad == -1)
                    for (int i = N - 1; i >= 0; i--)
                        if (obs_w[i] !== line[i*DW +: DW]) bad = i;
                checks++;
                if (bad != -1) begin errors++;
                    $display("FAIL rnd%0d_wdata: %0d beats, first bad %0d, required 16 in order",
                             k, obs_w.size(), bad); end
            end
            checks++;
            if (data_from_bus !== exp_buf) begin errors++;
                $display("FAIL rnd%0d_buf: word %0d got %h, required %h", k,
                         first_diff(data_from_bus, exp_buf),
                         data_from_bus[first_diff(data_from_bus, exp_buf)*DW +: DW],
                         exp_buf[first_diff(data_from_bus, exp_buf)*DW +: DW]); end
            @(posedge clk); #1;
            idle_inputs();
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        exp_buf = '0;
        test_reset();
        test_read_zero_wait();
        test_store_stalls();
        test_req_stall();
        test_read_then_writeback();
        test_reset_mid_read();
        test_spurious();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
